multicycle_ctrl: RTL

//  Main control FSM of the multi-cycle MIPS core; sits upstream of the PC register and drives its PCWrite.

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
// Carries the IR fields and ALU flag in, and every datapath select and enable out.
interface multicycle_ctrl_if #(
  parameter int OPW = 6,
  parameter int FNW = 6
);
  logic [OPW-1:0] OpCode;
  logic [FNW-1:0] Funct;
  logic           Zero;

  logic           PCWrite;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           RegWrite;
  logic [1:0]     RegDst;
  logic [1:0]     MemtoReg;
  logic [1:0]     ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [2:0]     ALUOp;
  logic [1:0]     PCSource;
  logic           instr_done;

  modport master (
    input  OpCode, Funct, Zero,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done
  );

  modport slave (
    output OpCode, Funct, Zero,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences IF/ID/EX/MEM/WB per
// instruction class and drives every datapath select, write enable and the retire pulse.
module multicycle_ctrl #(
  parameter int         OPW    = 6,
  parameter int         FNW    = 6,
  parameter logic [1:0] RA_SEL = 2'b10
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_LW, C_SW, C_R, C_JR, C_IMM, C_BEQ, C_BNE, C_J, C_JAL
  } cls_t;

  localparam logic [OPW-1:0] OP_R     = 'h00;
  localparam logic [OPW-1:0] OP_J     = 'h02;
  localparam logic [OPW-1:0] OP_JAL   = 'h03;
  localparam logic [OPW-1:0] OP_BEQ   = 'h04;
  localparam logic [OPW-1:0] OP_BNE   = 'h05;
  localparam logic [OPW-1:0] OP_ADDI  = 'h08;
  localparam logic [OPW-1:0] OP_ADDIU = 'h09;
  localparam logic [OPW-1:0] OP_SLTI  = 'h0A;
  localparam logic [OPW-1:0] OP_SLTIU = 'h0B;
  localparam logic [OPW-1:0] OP_ANDI  = 'h0C;
  localparam logic [OPW-1:0] OP_ORI   = 'h0D;
  localparam logic [OPW-1:0] OP_LUI   = 'h0F;
  localparam logic [OPW-1:0] OP_LW    = 'h23;
  localparam logic [OPW-1:0] OP_SW    = 'h2B;

  localparam logic [FNW-1:0] FN_SLL   = 'h00;
  localparam logic [FNW-1:0] FN_SRL   = 'h02;
  localparam logic [FNW-1:0] FN_SRA   = 'h03;
  localparam logic [FNW-1:0] FN_JR    = 'h08;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_R    = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_LUI  = 3'b111;

  state_t     state;
  state_t     state_next;
  cls_t       cls;
  logic [2:0] imm_alu_op;
  logic       is_shift;

  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       done;

  // Instruction class from the IR; only meaningful once the IR is loaded (ID onward).
  always_comb begin
    cls = C_NOP;
    case (bus.OpCode)
      OP_R:     cls = (bus.Funct == FN_JR) ? C_JR : C_R;
      OP_J:     cls = C_J;
      OP_JAL:   cls = C_JAL;
      OP_BEQ:   cls = C_BEQ;
      OP_BNE:   cls = C_BNE;
      OP_LW:    cls = C_LW;
      OP_SW:    cls = C_SW;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_LUI:
                cls = C_IMM;
      default:  cls = C_NOP;
    endcase
  end

  always_comb begin
    imm_alu_op = ALU_ADD;
    case (bus.OpCode)
      OP_ANDI:  imm_alu_op = ALU_AND;
      OP_ORI:   imm_alu_op = ALU_OR;
      OP_SLTI:  imm_alu_op = ALU_SLT;
      OP_SLTIU: imm_alu_op = ALU_SLTU;
      OP_LUI:   imm_alu_op = ALU_LUI;
      default:  imm_alu_op = ALU_ADD;
    endcase
  end

  assign is_shift = (bus.Funct == FN_SLL) || (bus.Funct == FN_SRL) ||
                    (bus.Funct == FN_SRA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_IF;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_source  = 2'b00;
    done       = 1'b0;

    case (state)
      S_IF: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
        state_next = S_ID;
      end

      // ALU precomputes the branch target into ALUOut while the class is decoded.
      S_ID: begin
        alu_src_b = 2'b11;
        case (cls)
          C_LW, C_SW, C_R, C_IMM, C_BEQ, C_BNE: state_next = S_EX;
          C_J: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            done      = 1'b1;
          end
          C_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = RA_SEL;
            mem_to_reg = 2'b10;
            done       = 1'b1;
          end
          C_JR: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
            done      = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end

      S_EX: begin
        case (cls)
          C_LW, C_SW: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            state_next = S_MEM;
          end
          C_R: begin
            alu_src_a  = is_shift ? 2'b10 : 2'b01;
            alu_op     = ALU_R;
            state_next = S_WB;
          end
          C_IMM: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            alu_op     = imm_alu_op;
            state_next = S_WB;
          end
          C_BEQ, C_BNE: begin
            alu_src_a = 2'b01;
            alu_op    = ALU_SUB;
            pc_source = 2'b01;
            pc_write  = (cls == C_BEQ) ? bus.Zero : ~bus.Zero;
            done      = 1'b1;
          end
          default: state_next = S_IF;
        endcase
      end

      S_MEM: begin
        iord = 1'b1;
        if (cls == C_LW) begin
          mem_read   = 1'b1;
          state_next = S_WB;
        end else if (cls == C_SW) begin
          mem_write = 1'b1;
          done      = 1'b1;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        case (cls)
          C_LW:    mem_to_reg = 2'b01;
          C_R:     reg_dst    = 2'b01;
          default: reg_dst    = 2'b00;
        endcase
      end

      default: state_next = S_IF;
    endcase

    // Nothing is enabled or selected while reset is held, even in the IF state.
    if (reset) begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      pc_source  = 2'b00;
      done       = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IorD       = iord;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUOp      = alu_op;
  assign bus.PCSource   = pc_source;
  assign bus.instr_done = done;

  assign state_o = reset ? 3'd0 : state;

endmodule
